// File: rtl/aes_dec_key_streamer_pkg.sv
// Shared AES-128 definitions for the decrypt key streamer: sizes, FSM encoding,
// S-box, Rcon and InvMixColumns helpers.
package aes_dec_key_streamer_pkg;

    localparam int unsigned KEY_WIDTH = 128;
    localparam int unsigned NR        = 10;
    localparam int unsigned IDX_W     = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EXPAND = 2'b01,
        STREAM = 2'b10
    } state_e;

    // Forward S-box, byte 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte x sits at bits [2047-8x -: 8]; 2047-8x == {~x, 3'b111} in 11 bits.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] rcon_of(input logic [IDX_W-1:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // One InvMixColumns column; byte 0 is the top row (most significant byte).
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] s [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int j = 0; j < 4; j++) begin
            s[j]  = col[31-8*j -: 8];
            x2    = xtime(s[j]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[j] = x8 ^ s[j];
            mb[j] = x8 ^ x2 ^ s[j];
            md[j] = x8 ^ x4 ^ s[j];
            me[j] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [KEY_WIDTH-1:0] inv_mix_columns(input logic [KEY_WIDTH-1:0] k);
        return {inv_mix_col(k[127:96]), inv_mix_col(k[95:64]),
                inv_mix_col(k[63:32]),  inv_mix_col(k[31:0])};
    endfunction

endpackage

// File: rtl/aes_dec_key_streamer_if.sv
// Round-key stream: rk_valid/rk_ready handshake carrying rk_data and rk_index.
//   master: producer (key streamer)   slave: consumer (inverse-cipher datapath)
interface aes_dec_key_streamer_if;
    import aes_dec_key_streamer_pkg::*;

    logic                 rk_valid;
    logic                 rk_ready;
    logic [KEY_WIDTH-1:0] rk_data;
    logic [IDX_W-1:0]     rk_index;

    modport master (output rk_valid, output rk_data, output rk_index, input rk_ready);
    modport slave  (input rk_valid, input rk_data, input rk_index, output rk_ready);
endinterface

// File: rtl/aes_dec_key_streamer_key_round.sv
// Single AES-128 key-expansion step (combinational).
//   prev_key   : round key r-1
//   rcon       : round constant for round r
//   next_key_c : round key r
module aes_key_round
    import aes_dec_key_streamer_pkg::*;
(
    input  logic [KEY_WIDTH-1:0] prev_key,
    input  logic [7:0]           rcon,
    output logic [KEY_WIDTH-1:0] next_key_c
);

    logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;

    assign w0 = prev_key[127:96];
    assign w1 = prev_key[95:64];
    assign w2 = prev_key[63:32];
    assign w3 = prev_key[31:0];

    // RotWord then SubWord, Rcon folded into the leading byte.
    assign temp = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key_c = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_dec_key_streamer.sv
// AES-128 decrypt key streamer: expands the cipher key into an 11-entry bank, one
// round per cycle, then streams round keys 10..0 over a valid/ready handshake.
// Optional macro INV_MIXCOL_KEY_EN: keys for indices 9..1 are streamed as
// InvMixColumns(key) (equivalent inverse cipher form).
//   clk, rst : clock, asynchronous active-low reset
//   start,key: run request (taken only in IDLE) and cipher key sampled with it
//   busy     : high while expanding or streaming
//   done     : one-cycle pulse after round 0 is accepted
//   rk_if    : round-key stream (master side)
module aes_dec_key_streamer
    import aes_dec_key_streamer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [KEY_WIDTH-1:0]   key,
    output logic                   busy,
    output logic                   done,
    aes_dec_key_streamer_if.master rk_if
);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     round_q, round_d;
    logic                 valid_q, valid_d;
    logic [KEY_WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic                 busy_d, done_d;

    logic [KEY_WIDTH-1:0] bank_q [NR+1];
    logic                 bank_we_c;
    logic [IDX_W-1:0]     bank_waddr_c;
    logic [KEY_WIDTH-1:0] bank_wdata_c;

    logic [IDX_W-1:0]     prev_idx_c, next_idx_c;
    logic [KEY_WIDTH-1:0] next_key_c, stream_key_c;

    // Read ports clamped so index 0 never wraps out of the bank.
    assign prev_idx_c = (round_q == '0) ? '0 : round_q - IDX_W'(1);
    assign next_idx_c = (index_q == '0) ? '0 : index_q - IDX_W'(1);

    aes_key_round u_key_round (
        .prev_key   (bank_q[prev_idx_c]),
        .rcon       (rcon_of(round_q)),
        .next_key_c (next_key_c)
    );

    // Key offered after a handshake; round 10 is loaded straight from the expander.
`ifdef INV_MIXCOL_KEY_EN
    assign stream_key_c = (next_idx_c == '0) ? bank_q[next_idx_c]
                                             : inv_mix_columns(bank_q[next_idx_c]);
`else
    assign stream_key_c = bank_q[next_idx_c];
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        valid_d      = valid_q;
        data_d       = data_q;
        index_d      = index_q;
        done_d       = 1'b0;
        bank_we_c    = 1'b0;
        bank_waddr_c = round_q;
        bank_wdata_c = next_key_c;

        case (state_q)
            IDLE: begin
                // The done cycle is still IDLE but must not accept a new start.
                if (start && !done) begin
                    bank_we_c    = 1'b1;
                    bank_waddr_c = '0;
                    bank_wdata_c = key;
                    round_d      = IDX_W'(1);
                    state_d      = EXPAND;
                end
            end
            EXPAND: begin
                bank_we_c = 1'b1;
                round_d   = round_q + IDX_W'(1);
                if (round_q == IDX_W'(NR)) begin
                    round_d = '0;
                    state_d = STREAM;
                    valid_d = 1'b1;
                    data_d  = next_key_c;
                    index_d = IDX_W'(NR);
                end
            end
            STREAM: begin
                if (rk_if.rk_ready) begin
                    if (index_q != '0) begin
                        index_d = next_idx_c;
                        data_d  = stream_key_c;
                    end else begin
                        valid_d = 1'b0;
                        data_d  = '0;
                        index_d = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            round_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            index_q <= index_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Round-key bank; contents are always rewritten before being offered.
    always_ff @(posedge clk) begin
        if (bank_we_c) begin
            bank_q[bank_waddr_c] <= bank_wdata_c;
        end
    end

    assign rk_if.rk_valid = valid_q;
    assign rk_if.rk_data  = data_q;
    assign rk_if.rk_index = index_q;

endmodule

// File: tb/tb_aes_dec_key_streamer.sv
// Scoreboard bench for aes_dec_key_streamer: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_aes_dec_key_streamer;
    import aes_dec_key_streamer_pkg::*;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key   = '0;
    logic         busy;
    logic         done;

    aes_dec_key_streamer_if rk_if ();

    aes_dec_key_streamer dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .key   (key),
        .busy  (busy),
        .done  (done),
        .rk_if (rk_if)
    );

    always #5 clk = ~clk;

    // FIPS-197 round keys 0..10 for the two reference cipher keys.
    localparam logic [127:0] KA [11] = '{
        128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5};
    localparam logic [127:0] KB [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] data;
    } beat_t;

    beat_t exp_q [$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

`ifdef INV_MIXCOL_KEY_EN
    // Generic shift-and-add GF(2^8) multiply used by the InvMixColumns model.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_mix_model(input logic [127:0] k);
        logic [7:0]   coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        logic [127:0] r = '0;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef[(j - row + 4) % 4], k[127-32*c-8*j -: 8]);
                r[127-32*c-8*row -: 8] = acc;
            end
        end
        return r;
    endfunction
`endif

    function automatic logic [127:0] exp_key(input int run, input int idx);
        logic [127:0] k = (run == 0) ? KA[idx] : KB[idx];
`ifdef INV_MIXCOL_KEY_EN
        if (idx >= 1 && idx <= 9) k = inv_mix_model(k);
`endif
        return k;
    endfunction

    task automatic push_run(input int run, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) exp_q.push_back('{idx: 4'(i), data: exp_key(run, i)});
    endtask

    // Monitor: handshake compare, stall stability and done timing.
    logic         stalled  = 1'b0;
    logic         done_exp = 1'b0;
    logic [127:0] st_data;
    logic [3:0]   st_idx;
    beat_t        got;

    always @(negedge clk) begin
        if (!rst) begin
            stalled  = 1'b0;
            done_exp = 1'b0;
        end else begin
            check("done_pulse", 128'(done), 128'(done_exp));
            done_exp = 1'b0;
            if (stalled) begin
                check("stall_valid", 128'(rk_if.rk_valid), 128'(1'b1));
                check("stall_data", rk_if.rk_data, st_data);
                check("stall_index", 128'(rk_if.rk_index), 128'(st_idx));
            end
            stalled = 1'b0;
            if (rk_if.rk_valid && rk_if.rk_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got index %0d data %h, expected none",
                             rk_if.rk_index, rk_if.rk_data);
                end else begin
                    got = exp_q.pop_front();
                    check("beat_index", 128'(rk_if.rk_index), 128'(got.idx));
                    check("beat_data", rk_if.rk_data, got.data);
                end
                if (rk_if.rk_index == 4'd0) done_exp = 1'b1;
            end else if (rk_if.rk_valid) begin
                stalled = 1'b1;
                st_data = rk_if.rk_data;
                st_idx  = rk_if.rk_index;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_done: done not seen within %0d cycles", budget);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 128'(busy), 128'(1'b0));
        check({tag, "_valid"}, 128'(rk_if.rk_valid), 128'(1'b0));
        check({tag, "_done"}, 128'(done), 128'(1'b0));
        check({tag, "_data"}, rk_if.rk_data, 128'h0);
        check({tag, "_index"}, 128'(rk_if.rk_index), 128'h0);
    endtask

    initial begin
        int n;
        rk_if.rk_ready = 1'b0;
        #1 rst = 1'b0;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b1;
        tick();

        // Run 1: latency, back-to-back streaming, done once.
        key = KA[0];
        rk_if.rk_ready = 1'b1;
        push_run(0, 10, 0);
        start = 1'b1;
        n = 0;
        while (!rk_if.rk_valid && n < 30) begin
            tick();
            n++;
            start = 1'b0;
        end
        check("first_valid_latency", 128'(n), 128'(11));
        n = 0;
        while (!done && n < 30) begin
            tick();
            n++;
        end
        check("stream_cycles_to_done", 128'(n), 128'(11));
        check("done_cycle_busy", 128'(busy), 128'(1'b0));
        tick();
        tick();

        // Run 2: second reference key, ready high.
        key = KB[0];
        push_run(1, 10, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        key = '0;
        wait_done(40);
        tick();

        // Run 3: random backpressure.
        key = KB[0];
        push_run(1, 10, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 300) begin
            rk_if.rk_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("random_ready_done", 128'(done), 128'(1'b1));
        rk_if.rk_ready = 1'b1;
        tick();

        // Run 4: start held high, key changed mid-expansion.
        key = KA[0];
        push_run(0, 10, 0);
        push_run(1, 10, 0);
        start = 1'b1;
        tick();
        tick();
        tick();
        key = KB[0];
        wait_done(40);
        tick();
        check("restart_idle_after_done", 128'(busy), 128'(1'b0));
        tick();
        check("restart_busy", 128'(busy), 128'(1'b1));
        start = 1'b0;
        key = '0;
        wait_done(40);
        tick();

        // Run 5a: reset in the fifth expansion cycle.
        key = KA[0];
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("expand_busy", 128'(busy), 128'(1'b1));
        rst = 1'b0;
        #1 check_zero("rst_expand");
        tick();
        rst = 1'b1;
        tick();

        // Run 5b: reset while index 6 is offered.
        push_run(0, 10, 7);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(rk_if.rk_valid && rk_if.rk_index == 4'd6) && n < 40) begin
            tick();
            n++;
        end
        check("reach_index6", 128'(rk_if.rk_index), 128'(6));
        rst = 1'b0;
        #1 check_zero("rst_stream");
        tick();
        rst = 1'b1;
        tick();
        tick();

        // Run 5c: clean run after the aborted ones.
        key = KB[0];
        push_run(1, 10, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(40);
        tick();
        tick();

        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
